// File: rtl/otter_mem_port_arbiter_if.sv
// Bus bundle between the OTTER pipeline's two memory ports (fetch IF, data D),
// the shared memory (M) and the arbiter that multiplexes them.
//
// Handshake: a requester raises x_REQ with its fields and holds them stable
// until the arbiter answers with a one-cycle x_ACK. x_DATA is valid in that
// ACK cycle. The requester may present its next request in the ACK cycle.
// Toward memory, M_REQ is held with its fields until the cycle M_ACK=1.
// M_RDATA is valid in that same cycle. M_ACK is ignored while M_REQ=0.
interface otter_mem_port_arbiter_if;
  logic        IF_REQ;
  logic [31:0] IF_ADDR;
  logic        IF_ACK;
  logic [31:0] IF_DATA;

  logic        D_REQ;
  logic        D_WE;
  logic [31:0] D_ADDR;
  logic [31:0] D_WDATA;
  logic [1:0]  D_SIZE;
  logic        D_SIGN;
  logic        D_ACK;
  logic [31:0] D_RDATA;

  logic        M_REQ;
  logic        M_WE;
  logic [31:0] M_ADDR;
  logic [31:0] M_WDATA;
  logic [1:0]  M_SIZE;
  logic        M_SIGN;
  logic        M_ACK;
  logic [31:0] M_RDATA;

  logic        ERR;

  // Environment side: the pipeline requesters plus the memory responder.
  modport master (
    output IF_REQ, IF_ADDR,
    input  IF_ACK, IF_DATA,
    output D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    input  D_ACK, D_RDATA,
    input  M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
    output M_ACK, M_RDATA,
    input  ERR
  );

  // Arbiter side.
  modport slave (
    input  IF_REQ, IF_ADDR,
    output IF_ACK, IF_DATA,
    input  D_REQ, D_WE, D_ADDR, D_WDATA, D_SIZE, D_SIGN,
    output D_ACK, D_RDATA,
    output M_REQ, M_WE, M_ADDR, M_WDATA, M_SIZE, M_SIGN,
    input  M_ACK, M_RDATA,
    output ERR
  );
endinterface

// File: rtl/otter_mem_port_arbiter.sv
// Shares one single-ported, variable-latency memory between OTTER instruction
// fetch and the MEM-stage data port. Data has fixed priority, but after
// MAX_D_BURST back-to-back data grants with a fetch waiting, the fetch is
// forced through. Each memory transaction is aborted after TIMEOUT busy
// cycles (0 = never), returning ERR_DATA with a one-cycle ERR pulse.
module otter_mem_port_arbiter #(
  parameter int          MAX_D_BURST = 4,
  parameter int          TIMEOUT     = 64,
  parameter logic [31:0] ERR_DATA    = 32'h0000_0000
) (
  input  logic                           CLK,
  input  logic                           RESET,
  otter_mem_port_arbiter_if.slave        bus,
  output logic [1:0]                     dbg_state
);

  localparam int BW = $clog2(MAX_D_BURST + 1);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [BW-1:0] BURST_LIMIT = BW'(MAX_D_BURST);
  localparam logic [TW-1:0] TO_LAST     = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          TO_EN       = (TIMEOUT > 0);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t        state;
  logic [BW-1:0] dburst;
  logic [TW-1:0] to_cnt;

  logic if_elig;
  logic d_elig;
  logic grant_d;
  logic grant_i;
  logic to_hit;

  assign dbg_state = state;

  // Grant decision: a requester whose ACK is high this cycle is swapping in
  // its next request and must not be granted at this edge.
  always_comb begin
    if_elig = bus.IF_REQ & ~bus.IF_ACK;
    d_elig  = bus.D_REQ & ~bus.D_ACK;
    grant_d = (state == IDLE) & d_elig & ((dburst < BURST_LIMIT) | ~if_elig);
    grant_i = (state == IDLE) & ~grant_d & if_elig;
    to_hit  = TO_EN & (to_cnt == TO_LAST);
  end

  // Grant FSM with registered outputs, burst limiter and timeout counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= IDLE;
      dburst      <= '0;
      to_cnt      <= '0;
      bus.IF_ACK  <= 1'b0;
      bus.IF_DATA <= '0;
      bus.D_ACK   <= 1'b0;
      bus.D_RDATA <= '0;
      bus.M_REQ   <= 1'b0;
      bus.M_WE    <= 1'b0;
      bus.M_ADDR  <= '0;
      bus.M_WDATA <= '0;
      bus.M_SIZE  <= '0;
      bus.M_SIGN  <= 1'b0;
      bus.ERR     <= 1'b0;
    end else begin
      bus.IF_ACK <= 1'b0;
      bus.D_ACK  <= 1'b0;
      bus.ERR    <= 1'b0;

      // Count data grants only while a fetch is actually waiting.
      if (!bus.IF_REQ || grant_i) begin
        dburst <= '0;
      end else if (grant_d && (dburst < BURST_LIMIT)) begin
        dburst <= dburst + 1'b1;
      end

      case (state)
        IDLE: begin
          if (grant_d) begin
            bus.M_REQ   <= 1'b1;
            bus.M_WE    <= bus.D_WE;
            bus.M_ADDR  <= bus.D_ADDR;
            bus.M_WDATA <= bus.D_WDATA;
            bus.M_SIZE  <= bus.D_SIZE;
            bus.M_SIGN  <= bus.D_SIGN;
            to_cnt      <= '0;
            state       <= BUSY_D;
          end else if (grant_i) begin
            // A fetch is always a full-word read.
            bus.M_REQ   <= 1'b1;
            bus.M_WE    <= 1'b0;
            bus.M_ADDR  <= bus.IF_ADDR;
            bus.M_WDATA <= '0;
            bus.M_SIZE  <= 2'b10;
            bus.M_SIGN  <= 1'b0;
            to_cnt      <= '0;
            state       <= BUSY_I;
          end
        end

        BUSY_I, BUSY_D: begin
          if (bus.M_ACK) begin
            // Memory answer beats a simultaneous timeout.
            bus.M_REQ <= 1'b0;
            if (state == BUSY_I) begin
              bus.IF_DATA <= bus.M_RDATA;
              bus.IF_ACK  <= 1'b1;
            end else begin
              bus.D_RDATA <= bus.M_RDATA;
              bus.D_ACK   <= 1'b1;
            end
            state <= IDLE;
          end else if (to_hit) begin
            bus.M_REQ <= 1'b0;
            bus.ERR   <= 1'b1;
            if (state == BUSY_I) begin
              bus.IF_DATA <= ERR_DATA;
              bus.IF_ACK  <= 1'b1;
            end else begin
              bus.D_RDATA <= ERR_DATA;
              bus.D_ACK   <= 1'b1;
            end
            state <= IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
